// File: rtl/cnt_sched_pkg.sv
// Shared types for the cnt_sched round-robin counter scheduler.
package cnt_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Width of a requester index; at least one bit.
    function automatic int unsigned idx_w(input int unsigned r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: first active request at or above ptr,
// wrapping to the lowest active request below ptr.
module rr_arb
    import cnt_sched_pkg::*;
#(
    parameter int unsigned R  = 4,
    parameter int unsigned IW = idx_w(R)
) (
    input  logic [R-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [R-1:0]  grant,
    output logic [IW-1:0] g,
    output logic          valid
);

    // Two-pass priority search: upper segment [ptr..R-1] first, then [0..R-1].
    always_comb begin
        grant = '0;
        g     = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < R; i++) begin
            if (!valid && req[i] && (IW'(i) >= ptr)) begin
                valid    = 1'b1;
                g        = IW'(i);
                grant[i] = 1'b1;
            end
        end
        for (int unsigned i = 0; i < R; i++) begin
            if (!valid && req[i]) begin
                valid    = 1'b1;
                g        = IW'(i);
                grant[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnt_sched.sv
// Round-robin scheduler time-sharing one up-counter between R requesters.
// Optional feature macro: CNT_SCHED_ABORT_EN (adds the abort input).
module cnt_sched
    import cnt_sched_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned R = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [R-1:0]        req,
    input  logic [R-1:0][N-1:0] len,
`ifdef CNT_SCHED_ABORT_EN
    input  logic                abort,
`endif
    output logic [R-1:0]        gnt,
    output logic                busy,
    output logic [R-1:0]        done,
    output logic [N-1:0]        q,
    output logic                max_tic
);

    localparam int unsigned IW = idx_w(R);

    state_t        state, state_n;
    logic [N-1:0]  q_n, tgt, tgt_n;
    logic [R-1:0]  gnt_n, done_n;
    logic [IW-1:0] ptr, ptr_n;
    logic [R-1:0]  arb_grant;
    logic [IW-1:0] arb_g;
    logic          arb_valid;
    logic          abort_w;

`ifdef CNT_SCHED_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    rr_arb #(
        .R  (R),
        .IW (IW)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_grant),
        .g     (arb_g),
        .valid (arb_valid)
    );

    // State and datapath registers; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            q     <= '0;
            tgt   <= '0;
            gnt   <= '0;
            done  <= '0;
            ptr   <= '0;
        end else begin
            state <= state_n;
            q     <= q_n;
            tgt   <= tgt_n;
            gnt   <= gnt_n;
            done  <= done_n;
            ptr   <= ptr_n;
        end
    end

    // Next-state, grant/done sequencing and counter clear/enable.
    always_comb begin
        state_n = state;
        q_n     = q;
        tgt_n   = tgt;
        gnt_n   = gnt;
        done_n  = '0;
        ptr_n   = ptr;
        unique case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_n = RUN;
                    gnt_n   = arb_grant;
                    tgt_n   = len[arb_g];
                    q_n     = '0;
                    ptr_n   = (arb_g == IW'(R - 1)) ? '0 : arb_g + IW'(1);
                end
            end
            RUN: begin
                if (abort_w) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    q_n     = '0;
                end else if (q == tgt) begin
                    state_n = DONE;
                    gnt_n   = '0;
                    done_n  = gnt;
                end else begin
                    q_n = q + N'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
                q_n     = '0;
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                q_n     = '0;
            end
        endcase
    end

    // Status decode: busy from the state register, max_tic straight from q.
    always_comb begin
        busy    = (state != IDLE);
        max_tic = (q == '1);
    end

endmodule

// File: tb/tb_cnt_sched.sv
// Self-checking bench for cnt_sched (N=4, R=4): cycle vector table plus
// hand-written reset / abort sequences.
module tb_cnt_sched;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [3:0]        req = '0;
    logic [3:0][3:0]   len = '0;
`ifdef CNT_SCHED_ABORT_EN
    logic              abort = 1'b0;
`endif
    logic [3:0]        gnt;
    logic              busy;
    logic [3:0]        done;
    logic [3:0]        q;
    logic              max_tic;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    typedef struct {
        string         name;
        logic [3:0]    req;
        logic [15:0]   len;
        logic [3:0]    gnt;
        logic [3:0]    done;
        logic          busy;
        logic [3:0]    q;
        logic          max_tic;
    } vec_t;

    vec_t vecs[$];

    cnt_sched #(
        .N (4),
        .R (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .len     (len),
`ifdef CNT_SCHED_ABORT_EN
        .abort   (abort),
`endif
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .q       (q),
        .max_tic (max_tic)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic check_all(input string nm, input logic [3:0] g, input logic [3:0] d,
                             input logic b, input logic [3:0] qq, input logic m);
        check({nm, ".gnt"},     32'(gnt),     32'(g));
        check({nm, ".done"},    32'(done),    32'(d));
        check({nm, ".busy"},    32'(busy),    32'(b));
        check({nm, ".q"},       32'(q),       32'(qq));
        check({nm, ".max_tic"}, 32'(max_tic), 32'(m));
    endtask

    function automatic void add(input string nm, input logic [3:0] r, input logic [15:0] l,
                                input logic [3:0] g, input logic [3:0] d, input logic b,
                                input logic [3:0] qq, input logic m);
        vec_t v;
        v.name = nm; v.req = r; v.len = l; v.gnt = g; v.done = d;
        v.busy = b; v.q = qq; v.max_tic = m;
        vecs.push_back(v);
    endfunction

    initial begin
        // Single interval: requester 0, len 3 (ptr 0 -> 1).
        add("single_g0",  4'b0001, 16'h0003, 4'b0001, 4'b0000, 1'b1, 4'd0, 1'b0);
        add("single_q1",  4'b0001, 16'h0003, 4'b0001, 4'b0000, 1'b1, 4'd1, 1'b0);
        add("single_q2",  4'b0001, 16'h0003, 4'b0001, 4'b0000, 1'b1, 4'd2, 1'b0);
        add("single_q3",  4'b0001, 16'h0003, 4'b0001, 4'b0000, 1'b1, 4'd3, 1'b0);
        add("single_dn",  4'b0000, 16'h0003, 4'b0000, 4'b0001, 1'b1, 4'd3, 1'b0);
        add("single_idl", 4'b0000, 16'h0003, 4'b0000, 4'b0000, 1'b0, 4'd0, 1'b0);
        // Contention: req 1010 held, len 2 each; grants 1, 3, 1.
        for (int k = 0; k < 3; k++) begin
            logic [3:0] gexp;
            gexp = (k == 1) ? 4'b1000 : 4'b0010;
            add("cont_g",  4'b1010, 16'h2222, gexp, 4'b0000, 1'b1, 4'd0, 1'b0);
            add("cont_q1", 4'b1010, 16'h2222, gexp, 4'b0000, 1'b1, 4'd1, 1'b0);
            add("cont_q2", 4'b1010, 16'h2222, gexp, 4'b0000, 1'b1, 4'd2, 1'b0);
            add("cont_dn", (k == 2) ? 4'b0000 : 4'b1010, 16'h2222, 4'b0000, gexp, 1'b1, 4'd2, 1'b0);
            add("cont_idl", (k == 2) ? 4'b0000 : 4'b1010, 16'h2222, 4'b0000, 4'b0000, 1'b0, 4'd0, 1'b0);
        end
        // Full-scale interval on requester 2 (ptr 2).
        add("max_g", 4'b0100, 16'h0F00, 4'b0100, 4'b0000, 1'b1, 4'd0, 1'b0);
        for (int k = 1; k <= 15; k++)
            add("max_cnt", 4'b0100, 16'h0F00, 4'b0100, 4'b0000, 1'b1, 4'(k), (k == 15));
        add("max_dn",  4'b0000, 16'h0F00, 4'b0000, 4'b0100, 1'b1, 4'd15, 1'b1);
        add("max_idl", 4'b0000, 16'h0F00, 4'b0000, 4'b0000, 1'b0, 4'd0, 1'b0);
        // Zero-length interval on requester 1 (ptr 3 wraps to 1).
        add("zero_g",   4'b0010, 16'h0000, 4'b0010, 4'b0000, 1'b1, 4'd0, 1'b0);
        add("zero_dn",  4'b0000, 16'h0000, 4'b0000, 4'b0010, 1'b1, 4'd0, 1'b0);
        add("zero_idl", 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 4'd0, 1'b0);

        // Asynchronous reset with no clock edge.
        #1 rst = 1'b1;
        #1 check_all("reset", 4'b0000, 4'b0000, 1'b0, 4'd0, 1'b0);
        tick();
        rst = 1'b0;

        foreach (vecs[i]) begin
            req = vecs[i].req;
            len = vecs[i].len;
            tick();
            check_all(vecs[i].name, vecs[i].gnt, vecs[i].done, vecs[i].busy,
                      vecs[i].q, vecs[i].max_tic);
        end

        // Reset mid-interval at q = 5: ptr is 2 here, requester 0 wins by wrap.
        req = 4'b0001;
        len = 16'h0009;
        tick();
        check_all("rrun_g", 4'b0001, 4'b0000, 1'b1, 4'd0, 1'b0);
        for (int k = 0; k < 5; k++) tick();
        check("rrun_q5", 32'(q), 32'd5);
        #2 rst = 1'b1;
        #1 check_all("rrun_async", 4'b0000, 4'b0000, 1'b0, 4'd0, 1'b0);
        req = 4'b0011;
        len = 16'h0001;
        tick();
        check_all("rrun_hold", 4'b0000, 4'b0000, 1'b0, 4'd0, 1'b0);
        rst = 1'b0;
        // ptr back to 0: requester 0 beats requester 1.
        tick();
        check_all("rrun_ptr0", 4'b0001, 4'b0000, 1'b1, 4'd0, 1'b0);
        tick();
        check_all("rrun_q1", 4'b0001, 4'b0000, 1'b1, 4'd1, 1'b0);
        tick();
        check_all("rrun_dn", 4'b0000, 4'b0001, 1'b1, 4'd1, 1'b0);
        tick();
        check_all("rrun_idl", 4'b0000, 4'b0000, 1'b0, 4'd0, 1'b0);
        tick();
        check_all("rrun_next", 4'b0010, 4'b0000, 1'b1, 4'd0, 1'b0);
        req = 4'b0000;
        tick();
        tick();
        tick();
        check_all("rrun_end", 4'b0000, 4'b0000, 1'b0, 4'd0, 1'b0);

`ifdef CNT_SCHED_ABORT_EN
        // Abort at q = 2 with len 7: back to IDLE, no done, requester 1 next.
        rst = 1'b1;
        #1 rst = 1'b0;
        req = 4'b0011;
        len = 16'h7777;
        tick();
        check_all("ab_g", 4'b0001, 4'b0000, 1'b1, 4'd0, 1'b0);
        tick();
        tick();
        check("ab_q2", 32'(q), 32'd2);
        abort = 1'b1;
        req   = 4'b0010;
        tick();
        abort = 1'b0;
        check_all("ab_idle", 4'b0000, 4'b0000, 1'b0, 4'd0, 1'b0);
        tick();
        check_all("ab_next", 4'b0010, 4'b0000, 1'b1, 4'd0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cnt_sched.md
# cnt_sched

Round-robin scheduler that time-shares one up-counter between R requesters. Each requester asks for an interval of its programmed length; the block grants the counter to one requester at a time, counts the interval, and signals completion. It sits between requesting control logic and the counter datapath, and owns the counter's clear, load and enable sequencing.

## Interface
- N, default 4: counter width in bits. Interval lengths range from 0 to 2^N-1.
- R, default 4: number of requesters, R ≥ 2.
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  R  per-requester request level; held high until `done` for that requester.
- len  input  R×N  packed `[R-1:0][N-1:0]`; requester i's interval target, sampled at grant.
- gnt  output  R  one-hot grant, high during RUN only.
- busy  output  1  high in RUN and DONE.
- done  output  R  one-hot, one-cycle completion pulse.
- q  output  N  current count.
- max_tic  output  1  combinational `q == 2^N-1`.

## Operation
- FSM states are IDLE, RUN and DONE.
- **Reset values:** state = IDLE, q = 0, gnt = 0, done = 0, busy = 0, ptr = 0.
- **IDLE:**
  - If `req != 0`, select winner g by round-robin starting at ptr, then ptr+1, … mod R.
  - At the next edge: state ← RUN, gnt ← onehot(g), tgt ← len[g], q ← 0, ptr ← (g+1) mod R.
  - If `req == 0`, stay in IDLE.
- **RUN:**
  - If `q != tgt`: q ← q+1.
  - If `q == tgt`: state ← DONE, gnt ← 0, done ← onehot(g), q holds.
  - Changes to `req` or `len` during RUN are ignored.
- **DONE:**
  - Lasts exactly one cycle with `done` asserted.
  - Next edge: state ← IDLE, done ← 0, q ← 0.
  - `req` is not sampled in DONE.
- **Arithmetic:** tgt ≤ 2^N-1, so q never wraps. len = 2^N-1 reaches max_tic and then completes.
- **len = 0:** one RUN cycle with q = 0, then DONE.
- **Mid-operation reset:** rst clears all state immediately. No `done` pulse is emitted for the interrupted interval.

## Timing
- req → gnt latency: 1 cycle, from IDLE.
- gnt duration: len+1 cycles.
- done fires in the cycle after the last RUN cycle (q == tgt).
- Minimum period per interval: len+3 cycles (IDLE, RUN×(len+1), DONE). Back-to-back grants are separated by one IDLE cycle.
- All outputs are registered except max_tic.
- A requester that drops `req` before grant is never granted.

## Configuration
- Macro: `CNT_SCHED_ABORT_EN`.
- **Defined:**
  - Adds input port `abort` (1 bit).
  - In RUN with abort = 1, the next edge sets state ← IDLE, gnt ← 0, q ← 0, and emits no `done`. ptr keeps its value already advanced at grant.
  - abort is ignored in IDLE and DONE.
  - If abort and `q == tgt` occur in the same cycle, abort wins.
- **Undefined:** no `abort` port; every granted interval runs to completion.

## Structure
- **Package `cnt_sched_pkg`:** `state_t` enum {IDLE, RUN, DONE}.
- **Sub-module `rr_arb`:** combinational round-robin arbiter.
  - Inputs: req[R], ptr.
  - Outputs: onehot grant[R], index g, valid.
  - The FSM owns ptr.
- The counter is implemented inline as a clear/enable register. The existing free-running counter has no clear or load, so it is not reused.

## Test plan
1. **Reset:** assert rst mid-cycle, no clock edge → q = 0, gnt = 0, done = 0, busy = 0 immediately.
2. **Single interval:** req = 0001, len[0] = 3 → gnt = 0001 from next cycle; q = 0,1,2,3; then done = 0001 for one cycle; busy low afterwards.
3. **Contention:** req = 1010 held, all len = 2 → grants in order 0010, 1000, 0010; each done pulses once in matching order.
4. **Boundaries:**
   - len[2] = 15 → max_tic = 1 only while q = 15, done follows, q does not wrap.
   - len[1] = 0 → one RUN cycle, then done.
5. **Async reset during RUN:** assert rst at q = 5 → all outputs reset at once, no done; then req = 0001 → grant to requester 0 (ptr = 0).
6. **Abort (CNT_SCHED_ABORT_EN):** abort at q = 2 with len = 7 → IDLE next cycle, no done; a pending req from the next index is granted one cycle later.
